// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fsm
// Description : RV64I/M instruction control FSM (IDLE/EXEC/MEM/WB). Latches
//               an accepted instruction, decodes it into one-hot ALU control,
//               waits on multi-cycle mul/div, and sequences load/store
//               handshakes and register write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fsm #(
    parameter int ALU_OPW  = 17,
    parameter bit EN_M     = 1'b1,
    parameter bit EN_RV64  = 1'b1,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [31:0]        inst,
    input  logic               alu_done,
    output logic               lsu_req,
    output logic               lsu_wen,
    output logic [7:0]         lsu_wmask,
    input  logic               lsu_ack,
    output logic [ALU_OPW-1:0] alu_control,
    output logic               w_choose,
    output logic               rf_wen,
    output logic [2:0]         sel_rf_res,
    output logic               illegal,
    output logic               busy
);

    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_OPW    = 7'b0111011;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    localparam int c_ADD = 0,  c_SUB = 1,  c_SLT = 2,  c_SLTU = 3, c_AND = 4;
    localparam int c_OR  = 6,  c_XOR = 7,  c_SLL = 8,  c_SRL  = 9, c_SRA = 10;
    localparam int c_LUI = 11, c_MUL = 12, c_DIVU = 13, c_DIV = 14;
    localparam int c_REMU = 15, c_REM = 16;

    localparam logic [2:0] c_SEL_ALU = 3'b001;
    localparam logic [2:0] c_SEL_LD  = 3'b010;
    localparam logic [2:0] c_SEL_CSR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_inst;
    logic [c_WAIT_W-1:0] r_wait;

    logic [16:0] w_op;
    logic [16:0] w_op_out;
    logic        w_w;
    logic [2:0]  w_sel;
    logic        w_legal;
    logic        w_ld;
    logic        w_st;
    logic        w_md;
    logic        w_wr;
    logic [7:0]  w_mask;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_unused;

    assign w_f3     = r_inst[14:12];
    assign w_f7     = r_inst[31:25];
    // rs1/rs2 fields and low immediate bits are consumed by the datapath only
    assign w_unused = ^r_inst[24:15];

    // Decode the latched instruction into operation, result select and class
    always_comb begin
        w_op    = '0;
        w_w     = 1'b0;
        w_sel   = 3'b000;
        w_legal = 1'b0;
        w_ld    = 1'b0;
        w_st    = 1'b0;
        w_md    = 1'b0;
        w_wr    = 1'b0;
        w_mask  = 8'h00;
        case (r_inst[6:0])
            c_OPC_LUI: begin
                w_op[c_LUI] = 1'b1; w_sel = c_SEL_ALU; w_wr = 1'b1; w_legal = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_op[c_ADD] = 1'b1; w_sel = c_SEL_ALU; w_wr = 1'b1; w_legal = 1'b1;
            end
            c_OPC_OPIMM: begin
                w_sel = c_SEL_ALU; w_wr = 1'b1; w_legal = 1'b1;
                case (w_f3)
                    3'b000: w_op[c_ADD]  = 1'b1;
                    3'b010: w_op[c_SLT]  = 1'b1;
                    3'b011: w_op[c_SLTU] = 1'b1;
                    3'b100: w_op[c_XOR]  = 1'b1;
                    3'b110: w_op[c_OR]   = 1'b1;
                    3'b111: w_op[c_AND]  = 1'b1;
                    3'b001: begin
                        if (r_inst[31:26] == 6'b000000) w_op[c_SLL] = 1'b1;
                        else                            w_legal = 1'b0;
                    end
                    default: begin
                        if (r_inst[31:26] == 6'b000000)      w_op[c_SRL] = 1'b1;
                        else if (r_inst[31:26] == 6'b010000) w_op[c_SRA] = 1'b1;
                        else                                 w_legal = 1'b0;
                    end
                endcase
                // a 6-bit shift amount needs the 64-bit datapath
                if (!EN_RV64 && w_f3[1:0] == 2'b01 && r_inst[25]) w_legal = 1'b0;
            end
            c_OPC_OP: begin
                w_sel = c_SEL_ALU; w_wr = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    case (w_f3)
                        3'b000:  w_op[c_ADD]  = 1'b1;
                        3'b001:  w_op[c_SLL]  = 1'b1;
                        3'b010:  w_op[c_SLT]  = 1'b1;
                        3'b011:  w_op[c_SLTU] = 1'b1;
                        3'b100:  w_op[c_XOR]  = 1'b1;
                        3'b101:  w_op[c_SRL]  = 1'b1;
                        3'b110:  w_op[c_OR]   = 1'b1;
                        default: w_op[c_AND]  = 1'b1;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000) begin w_op[c_SUB] = 1'b1; w_legal = 1'b1; end
                    if (w_f3 == 3'b101) begin w_op[c_SRA] = 1'b1; w_legal = 1'b1; end
                end else if (w_f7 == 7'b0000001 && EN_M) begin
                    // mulh* have no ALU encoding and stay illegal
                    w_md = 1'b1; w_legal = 1'b1;
                    case (w_f3)
                        3'b000:  w_op[c_MUL]  = 1'b1;
                        3'b100:  w_op[c_DIV]  = 1'b1;
                        3'b101:  w_op[c_DIVU] = 1'b1;
                        3'b110:  w_op[c_REM]  = 1'b1;
                        3'b111:  w_op[c_REMU] = 1'b1;
                        default: w_legal = 1'b0;
                    endcase
                end
            end
            c_OPC_OPIMMW: begin
                w_sel = c_SEL_ALU; w_wr = 1'b1; w_w = 1'b1;
                if (EN_RV64) begin
                    if (w_f3 == 3'b000) begin w_op[c_ADD] = 1'b1; w_legal = 1'b1; end
                    if (w_f3 == 3'b001 && w_f7 == 7'b0000000) begin w_op[c_SLL] = 1'b1; w_legal = 1'b1; end
                    if (w_f3 == 3'b101 && w_f7 == 7'b0000000) begin w_op[c_SRL] = 1'b1; w_legal = 1'b1; end
                    if (w_f3 == 3'b101 && w_f7 == 7'b0100000) begin w_op[c_SRA] = 1'b1; w_legal = 1'b1; end
                end
            end
            c_OPC_OPW: begin
                w_sel = c_SEL_ALU; w_wr = 1'b1; w_w = 1'b1;
                if (EN_RV64) begin
                    if (w_f7 == 7'b0000000) begin
                        if (w_f3 == 3'b000) begin w_op[c_ADD] = 1'b1; w_legal = 1'b1; end
                        if (w_f3 == 3'b001) begin w_op[c_SLL] = 1'b1; w_legal = 1'b1; end
                        if (w_f3 == 3'b101) begin w_op[c_SRL] = 1'b1; w_legal = 1'b1; end
                    end else if (w_f7 == 7'b0100000) begin
                        if (w_f3 == 3'b000) begin w_op[c_SUB] = 1'b1; w_legal = 1'b1; end
                        if (w_f3 == 3'b101) begin w_op[c_SRA] = 1'b1; w_legal = 1'b1; end
                    end else if (w_f7 == 7'b0000001 && EN_M) begin
                        w_md = 1'b1; w_legal = 1'b1;
                        case (w_f3)
                            3'b000:  w_op[c_MUL]  = 1'b1;
                            3'b100:  w_op[c_DIV]  = 1'b1;
                            3'b101:  w_op[c_DIVU] = 1'b1;
                            3'b110:  w_op[c_REM]  = 1'b1;
                            3'b111:  w_op[c_REMU] = 1'b1;
                            default: w_legal = 1'b0;
                        endcase
                    end
                end
            end
            c_OPC_LOAD: begin
                // the ALU forms the effective address
                w_op[c_ADD] = 1'b1; w_sel = c_SEL_LD; w_wr = 1'b1; w_ld = 1'b1;
                case (w_f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = EN_RV64;
                    default:                                w_legal = 1'b0;
                endcase
            end
            c_OPC_STORE: begin
                w_op[c_ADD] = 1'b1; w_st = 1'b1;
                case (w_f3)
                    3'b000:  begin w_mask = 8'h01; w_legal = 1'b1;    end
                    3'b001:  begin w_mask = 8'h03; w_legal = 1'b1;    end
                    3'b010:  begin w_mask = 8'h0F; w_legal = 1'b1;    end
                    3'b011:  begin w_mask = 8'hFF; w_legal = EN_RV64; end
                    default: w_legal = 1'b0;
                endcase
            end
            c_OPC_SYSTEM: begin
                // only CSR accesses are handled here; ecall/ebreak are not
                if (w_f3 != 3'b000 && w_f3 != 3'b100) begin
                    w_sel = c_SEL_CSR; w_wr = 1'b1; w_legal = 1'b1;
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state and output logic; decoded controls are visible outside IDLE only
    always_comb begin
        w_next      = r_state;
        inst_ready  = 1'b0;
        lsu_req     = 1'b0;
        lsu_wen     = 1'b0;
        lsu_wmask   = 8'h00;
        rf_wen      = 1'b0;
        illegal     = 1'b0;
        w_op_out    = '0;
        w_choose    = 1'b0;
        sel_rf_res  = 3'b000;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) w_next = EXEC;
            end
            EXEC: begin
                if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = IDLE;
                end else if (w_md) begin
                    if (alu_done) begin
                        w_next = WB;
                    end else if (r_wait == c_WAIT_W'(MAX_WAIT - 1)) begin
                        illegal = 1'b1;
                        w_next  = IDLE;
                    end
                end else if (w_ld || w_st) begin
                    w_next = MEM;
                end else begin
                    w_next = WB;
                end
            end
            MEM: begin
                lsu_req   = 1'b1;
                lsu_wen   = w_st;
                lsu_wmask = w_mask;
                if (lsu_ack) w_next = w_ld ? WB : IDLE;
            end
            default: begin
                rf_wen = w_wr && (r_inst[11:7] != 5'd0);
                w_next = IDLE;
            end
        endcase
        if (r_state != IDLE && w_legal) begin
            w_op_out   = w_op;
            w_choose   = w_w;
            sel_rf_res = w_sel;
        end
    end

    // State, latched instruction and EXEC wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_inst  <= 32'd0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && inst_valid) r_inst <= inst;
            if (r_state == EXEC && w_next == EXEC) r_wait <= r_wait + c_WAIT_W'(1);
            else                                   r_wait <= '0;
        end
    end

    generate
        if (ALU_OPW > 17) begin : g_alu_wide
            assign alu_control = {{(ALU_OPW - 17){1'b0}}, w_op_out};
        end else begin : g_alu_narrow
            assign alu_control = w_op_out[ALU_OPW-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_fsm
// Description : Directed self-checking bench for ctrl_fsm (full RV64IM
//               instance plus an EN_M=0 / EN_RV64=0 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic        lite_valid;
    logic [31:0] inst;
    logic        alu_done;
    logic        lsu_ack;

    logic        inst_ready, lsu_req, lsu_wen, w_choose, rf_wen, illegal, busy;
    logic [7:0]  lsu_wmask;
    logic [16:0] alu_control;
    logic [2:0]  sel_rf_res;

    logic        l_inst_ready, l_lsu_req, l_lsu_wen, l_w_choose, l_rf_wen, l_illegal, l_busy;
    logic [7:0]  l_lsu_wmask;
    logic [11:0] l_alu_control;
    logic [2:0]  l_sel_rf_res;

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .alu_done(alu_done), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
        .lsu_wmask(lsu_wmask), .lsu_ack(lsu_ack), .alu_control(alu_control),
        .w_choose(w_choose), .rf_wen(rf_wen), .sel_rf_res(sel_rf_res),
        .illegal(illegal), .busy(busy)
    );

    ctrl_fsm #(.ALU_OPW(12), .EN_M(1'b0), .EN_RV64(1'b0), .MAX_WAIT(64)) dut_lite (
        .clk(clk), .rst_n(rst_n), .inst_valid(lite_valid), .inst_ready(l_inst_ready),
        .inst(inst), .alu_done(alu_done), .lsu_req(l_lsu_req), .lsu_wen(l_lsu_wen),
        .lsu_wmask(l_lsu_wmask), .lsu_ack(lsu_ack), .alu_control(l_alu_control),
        .w_choose(l_w_choose), .rf_wen(l_rf_wen), .sel_rf_res(l_sel_rf_res),
        .illegal(l_illegal), .busy(l_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present an instruction for one cycle, then scramble the bus
    task automatic issue(input logic [31:0] word);
        inst       = word;
        inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        inst       = 32'hFFFF_FFFF;
    endtask

    logic [31:0] st_inst [3];
    logic [7:0]  st_mask [3];

    initial begin
        int first_ill;
        int idle_at;
        logic any_wen;

        st_inst[0] = 32'h0020_8023; st_mask[0] = 8'h01;
        st_inst[1] = 32'h0020_9023; st_mask[1] = 8'h03;
        st_inst[2] = 32'h0020_A023; st_mask[2] = 8'h0F;

        inst_valid = 1'b0; lite_valid = 1'b0; inst = 32'd0;
        alu_done = 1'b0; lsu_ack = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_inst_ready", inst_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_outs", {lsu_req, lsu_wen, lsu_wmask, w_choose, rf_wen, sel_rf_res, illegal}, 0);
        check("rst_alu", alu_control, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // addi x1,x0,5
        issue(32'h0050_0093);
        check("addi_exec_alu", alu_control, 17'h00001);
        check("addi_exec_sel", sel_rf_res, 3'b001);
        check("addi_exec_ctl", {inst_ready, busy, rf_wen, illegal}, 4'b0100);
        tick();
        check("addi_wb_wen", rf_wen, 1);
        check("addi_wb_sel", sel_rf_res, 3'b001);
        tick();
        check("addi_idle", {inst_ready, busy, rf_wen, alu_control}, {3'b100, 17'h0});

        // addi x0,x0,5 must not write x0
        issue(32'h0050_0013);
        tick();
        check("rd0_no_wen", {busy, rf_wen}, 2'b10);
        tick();

        // ld x2,0(x1) with ack in the third MEM cycle
        issue(32'h0000_B103);
        check("ld_exec_req", lsu_req, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ld_mem_req", {lsu_req, lsu_wen, lsu_wmask}, {2'b10, 8'h00});
            if (i == 2) lsu_ack = 1'b1;
            tick();
        end
        lsu_ack = 1'b0;
        check("ld_wb", {lsu_req, rf_wen, sel_rf_res}, 5'b0_1_010);
        tick();
        check("ld_idle", inst_ready, 1);

        // sd x2,8(x1)
        issue(32'h0020_B423);
        tick();
        check("sd_mem", {lsu_req, lsu_wen, lsu_wmask, rf_wen}, {2'b11, 8'hFF, 1'b0});
        lsu_ack = 1'b1;
        tick();
        lsu_ack = 1'b0;
        check("sd_idle", {inst_ready, busy, rf_wen}, 3'b100);

        // sb / sh / sw byte masks
        for (int s = 0; s < 3; s++) begin
            issue(st_inst[s]);
            tick();
            check("st_mask", lsu_wmask, st_mask[s]);
            lsu_ack = 1'b1;
            tick();
            lsu_ack = 1'b0;
        end

        // mul x3,x1,x2 with alu_done in the fifth EXEC cycle
        issue(32'h0220_81B3);
        for (int k = 1; k <= 5; k++) begin
            check("mul_exec", {busy, rf_wen, alu_control}, {2'b10, 17'h01000});
            if (k == 5) alu_done = 1'b1;
            tick();
        end
        alu_done = 1'b0;
        check("mul_wb_wen", rf_wen, 1);
        tick();

        // mul with alu_done never asserted
        issue(32'h0220_81B3);
        first_ill = -1; idle_at = -1; any_wen = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (illegal && first_ill < 0) first_ill = k;
            any_wen = any_wen | rf_wen;
            if (!busy) begin idle_at = k; break; end
            tick();
        end
        check("mul_timeout_cycle", first_ill, 64);
        check("mul_timeout_idle", idle_at, 65);
        check("mul_timeout_nowen", any_wen, 0);

        // addw x4,x1,x2
        issue(32'h0020_823B);
        check("addw_exec", {alu_control, w_choose}, {17'h00001, 1'b1});
        tick();
        check("addw_wb", rf_wen, 1);
        tick();

        // undecodable opcode
        issue(32'hFFFF_FFFF);
        check("undec_ill", {illegal, rf_wen, lsu_req}, 3'b100);
        tick();
        check("undec_idle", {inst_ready, illegal, rf_wen}, 3'b100);

        // disabled M / RV64 ops on the reduced instance
        inst = 32'h0220_81B3; lite_valid = 1'b1; tick(); lite_valid = 1'b0;
        check("lite_mul_ill", {l_illegal, l_rf_wen, l_alu_control}, {2'b10, 12'h0});
        tick();
        check("lite_mul_idle", {l_inst_ready, l_rf_wen}, 2'b10);
        inst = 32'h0020_823B; lite_valid = 1'b1; tick(); lite_valid = 1'b0;
        check("lite_addw_ill", {l_illegal, l_rf_wen}, 2'b10);
        tick();
        check("lite_addw_idle", {l_inst_ready, l_rf_wen, l_illegal}, 3'b100);
        inst = 32'h0000_B103; lite_valid = 1'b1; tick(); lite_valid = 1'b0;
        check("lite_ld_ill", {l_illegal, l_lsu_req}, 2'b10);
        tick();
        check("lite_ld_noreq", {l_lsu_req, l_inst_ready}, 2'b01);
        inst = 32'h0050_0093; lite_valid = 1'b1; tick(); lite_valid = 1'b0;
        check("lite_addi_ok", {l_illegal, l_alu_control}, {1'b0, 12'h001});
        tick();
        check("lite_addi_wen", l_rf_wen, 1);
        tick();

        // reset in the middle of MEM
        issue(32'h0000_B103);
        tick();
        check("mem_before_rst", lsu_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mem_rst_async", {lsu_req, inst_ready, busy}, 3'b010);
        lsu_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("late_ack_ignored", {busy, inst_ready, rf_wen}, 3'b010);
        lsu_ack = 1'b0;

        // reset during a mul wait
        issue(32'h0220_81B3);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("exec_rst_async", {busy, inst_ready, alu_control}, {2'b01, 17'h0});
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Parameters
REQ-001 SHALL provide ALU_OPW, default 17: width of the one-hot alu_control vector; it SHALL be >=17 when EN_M=1 and >=12 otherwise.
REQ-002 SHALL provide EN_M, default 1: 1 makes RV64M mul/div/rem and their W forms legal; 0 makes them illegal.
REQ-003 SHALL provide EN_RV64, default 1: 1 makes ld/lwu/sd and all W-ops legal; 0 makes them illegal.
REQ-004 SHALL provide MAX_WAIT, default 64: number of EXEC cycles to wait for alu_done before timeout.

Interface
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 inst_valid  in  1  instruction offered.
REQ-008 inst_ready  out  1  block can accept an instruction.
REQ-009 inst  in  32  RV64I/M instruction word.
REQ-010 alu_done  in  1  multi-cycle mul/div result ready.
REQ-011 lsu_req / lsu_wen / lsu_wmask / lsu_ack  out 1 / out 1 / out 8 / in 1  memory request handshake; lsu_wmask is the store byte mask.
REQ-012 alu_control  out  ALU_OPW  one-hot operation: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui, 12 mul, 13 divu, 14 div, 15 remu, 16 rem.
REQ-013 w_choose  out  1  32-bit W-op; result is sign-extended downstream.
REQ-014 rf_wen / sel_rf_res  out 1 / out 3  register write enable; result select (001 alu, 010 load, 100 csr).
REQ-015 illegal / busy  out 1 / out 1  one-cycle illegal/timeout pulse; busy is high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, EXEC, MEM, WB.
REQ-017 inst_ready SHALL be 1 only in IDLE; on inst_valid&inst_ready, inst SHALL be latched and the state SHALL go to EXEC.
REQ-018 Decode SHALL use the latched instruction only; a change on inst after acceptance SHALL have no effect.
REQ-019 In EXEC, alu_control, w_choose and sel_rf_res SHALL be driven from the latched instruction.
  - These outputs SHALL hold through MEM and WB.
  - They SHALL be all-zero in IDLE.
REQ-020 remuw SHALL map to bit15 (remu), remw to bit16, divuw to bit13, divw to bit14.
REQ-021 Single-cycle ops SHALL leave EXEC after 1 cycle.
REQ-022 Mul/div/rem ops SHALL stay in EXEC until alu_done=1.
  - A wait counter SHALL clear on entry to EXEC.
  - On reaching MAX_WAIT cycles: pulse illegal, return to IDLE, no rf_wen.
REQ-023 From EXEC, loads and stores SHALL go to MEM; all other legal ops SHALL go to WB.
REQ-024 In MEM, lsu_req SHALL be held at 1 until the cycle lsu_ack=1.
  - lsu_wen SHALL be 1 for stores.
  - lsu_wmask SHALL be sb 01, sh 03, sw 0F, sd FF (hex) for stores and 00 for loads.
REQ-025 On lsu_ack, loads SHALL go to WB and stores SHALL go to IDLE.
  - lsu_ack outside MEM SHALL be ignored.
REQ-026 WB SHALL last exactly 1 cycle and then return to IDLE.
  - rf_wen=1 only in WB, and only when the op writes rd and rd!=0.
REQ-027 An undecodable or disabled instruction (EN_M/EN_RV64) SHALL pulse illegal for 1 cycle in EXEC, then return to IDLE with rf_wen and lsu_req kept 0.
REQ-028 Latency for a single-cycle ALU op: accept at T, EXEC at T+1, rf_wen at T+2, inst_ready=1 at T+3.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE and clear the wait counter and the latched instruction.
  - Resulting outputs: inst_ready=1, all other outputs 0.
  - This SHALL apply in any state, including mid-MEM (request dropped) and mid-EXEC wait.
REQ-030 After rst_n rises, the first acceptance SHALL occur no earlier than the first rising clk edge.

Verification
REQ-031 addi x1,x0,5 (00500093) -> alu_control bit0, sel_rf_res=001, rf_wen=1 exactly at T+2, illegal=0.
REQ-032 ld x2,0(x1) (0000B103), lsu_ack 3 cycles after lsu_req -> lsu_req high 3 cycles, lsu_wen=0, then WB rf_wen=1 with sel_rf_res=010.
REQ-033 sd x2,8(x1) (0020B423) -> lsu_wen=1, lsu_wmask=FF, no rf_wen; return to IDLE after ack.
REQ-034 Multi-cycle and disabled ops:
  - mul x3,x1,x2 (022081B3), alu_done after 5 cycles -> bit12 held 5 cycles, then rf_wen.
  - Same with alu_done never asserted -> illegal pulse after 64 cycles, no rf_wen.
  - Same with EN_M=0 -> illegal at T+1.
REQ-035 addw x4,x1,x2 (0020823B) -> bit0 and w_choose=1; with EN_RV64=0 -> illegal pulse, no rf_wen.
REQ-036 rst_n=0 mid-MEM -> lsu_req falls immediately, inst_ready=1; a late lsu_ack after reset is ignored.
